// File: rtl/hangman_pkg.sv
// ============================================================================
// hangman_pkg : shared states, key codes and letter classifier for the
//               hangman guess engine.                         Revision 1.0
// ============================================================================
`default_nettype none

package hangman_pkg;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_LOAD_DRAW = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SCAN      = 3'd3,
    ST_RESOLVE   = 3'd4,
    ST_DRAW      = 3'd5,
    ST_WON       = 3'd6,
    ST_LOST      = 3'd7
  } state_e;

  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] CHAR_A    = 8'h41;
  localparam logic [7:0] CHAR_Z    = 8'h5A;
  localparam int         ALPHA_N   = 26;

  function automatic logic is_letter(input logic [7:0] code);
    return (code >= CHAR_A) && (code <= CHAR_Z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hangman_word_store.sv
// ============================================================================
// hangman_word_store : secret-word register file with append pointer and
//                      combinational read port.               Revision 1.0
// ============================================================================
`default_nettype none

module hangman_word_store
  import hangman_pkg::*;
#(
  parameter int MAX_LEN = 10,
  parameter int CHAR_W  = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [CHAR_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [CHAR_W-1:0] rd_data_o,
  output logic [LEN_W-1:0]  len_o
);

  logic [CHAR_W-1:0] mem_q [MAX_LEN];
  logic [LEN_W-1:0]  len_q;
  logic              w_full;

  // Writes past the last slot are silently dropped.
  assign w_full = (len_q == LEN_W'(MAX_LEN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      len_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else if (wr_en_i && !w_full) begin
      mem_q[len_q[IDX_W-1:0]] <= wr_data_i;
      len_q                   <= len_q + LEN_W'(1);
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign len_o     = len_q;

endmodule

`default_nettype wire

// File: rtl/hangman_guess_engine.sv
// ============================================================================
// hangman_guess_engine : word load, per-position guess scan, miss/win/lose
//   tracking and redraw handshake. Option: HANGMAN_REPEAT_TRACK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module hangman_guess_engine
  import hangman_pkg::*;
#(
  parameter int MAX_LEN    = 10,
  parameter int CHAR_W     = 8,
  parameter int MAX_MISSES = 6,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              new_game,
  input  logic              key_valid,
  input  logic [CHAR_W-1:0] key_code,
  output logic              guess_ready,
  output logic [LEN_W-1:0]  word_len,
  output logic [MAX_LEN-1:0] revealed,
  output logic [MISS_W-1:0] miss_count,
  output logic              last_hit,
  output logic              draw_req,
  input  logic              draw_ack,
  output logic              won,
  output logic              lost
`ifdef HANGMAN_REPEAT_TRACK_EN
  ,
  output logic [ALPHA_N-1:0] used_letters
`endif
);

  localparam int IDX_W = $clog2(MAX_LEN);

  state_e             state_q, state_d;
  logic [CHAR_W-1:0]  guess_q, guess_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hit_q, hit_d;
  logic [MAX_LEN-1:0] revealed_q, revealed_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               last_hit_q, last_hit_d;

  logic               w_letter;
  logic               w_enter;
  logic               w_repeat;
  logic               w_wr_en;
  logic               w_scan_last;
  logic [CHAR_W-1:0]  w_rd_data;
  logic [LEN_W-1:0]   w_len;
  logic [MAX_LEN-1:0] w_len_mask;

  hangman_word_store #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) u_store (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .clr_i     (new_game),
    .wr_en_i   (w_wr_en),
    .wr_data_i (key_code),
    .rd_idx_i  (idx_q),
    .rd_data_o (w_rd_data),
    .len_o     (w_len)
  );

  // A letter code must also have zero upper bits when CHAR_W is wider than 8.
  assign w_letter = key_valid && is_letter(key_code[7:0])
                    && (key_code == CHAR_W'(key_code[7:0]));
  assign w_enter  = key_valid && (key_code == CHAR_W'(KEY_ENTER));
  assign w_scan_last = ((LEN_W'(idx_q) + LEN_W'(1)) == w_len);

  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) w_len_mask[i] = (LEN_W'(i) < w_len);
  end

`ifdef HANGMAN_REPEAT_TRACK_EN
  logic [ALPHA_N-1:0] used_q, used_d;
  logic [4:0]         w_key_idx;
  logic [4:0]         w_guess_idx;

  assign w_key_idx   = 5'(key_code[7:0] - CHAR_A);
  assign w_guess_idx = 5'(guess_q[7:0] - CHAR_A);
  assign w_repeat    = used_q[w_key_idx];
  assign used_letters = used_q;
`else
  assign w_repeat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    revealed_d = revealed_q;
    miss_d     = miss_q;
    last_hit_d = last_hit_q;
    w_wr_en    = 1'b0;
`ifdef HANGMAN_REPEAT_TRACK_EN
    used_d     = used_q;
`endif

    if (new_game) begin
      state_d    = ST_LOAD;
      guess_d    = '0;
      idx_d      = '0;
      hit_d      = 1'b0;
      revealed_d = '0;
      miss_d     = '0;
      last_hit_d = 1'b0;
`ifdef HANGMAN_REPEAT_TRACK_EN
      used_d     = '0;
`endif
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          w_wr_en = w_letter;
          if (w_enter && (w_len != '0)) state_d = ST_LOAD_DRAW;
        end
        ST_LOAD_DRAW: begin
          if (draw_ack) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (w_letter && !w_repeat) begin
            guess_d = key_code;
            idx_d   = '0;
            hit_d   = 1'b0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_rd_data == guess_q) begin
            revealed_d[idx_q] = 1'b1;
            hit_d             = 1'b1;
          end
          if (w_scan_last) state_d = ST_RESOLVE;
          else             idx_d   = idx_q + IDX_W'(1);
        end
        ST_RESOLVE: begin
          last_hit_d = hit_q;
          if (!hit_q && (miss_q != MISS_W'(MAX_MISSES))) miss_d = miss_q + MISS_W'(1);
`ifdef HANGMAN_REPEAT_TRACK_EN
          used_d[w_guess_idx] = 1'b1;
`endif
          state_d = ST_DRAW;
        end
        ST_DRAW: begin
          // Win takes precedence if the last letter and last miss coincide.
          if (draw_ack) begin
            if ((revealed_q & w_len_mask) == w_len_mask) state_d = ST_WON;
            else if (miss_q == MISS_W'(MAX_MISSES))       state_d = ST_LOST;
            else                                          state_d = ST_PLAY;
          end
        end
        ST_WON, ST_LOST: ;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_LOAD;
      guess_q    <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      revealed_q <= '0;
      miss_q     <= '0;
      last_hit_q <= 1'b0;
`ifdef HANGMAN_REPEAT_TRACK_EN
      used_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      revealed_q <= revealed_d;
      miss_q     <= miss_d;
      last_hit_q <= last_hit_d;
`ifdef HANGMAN_REPEAT_TRACK_EN
      used_q     <= used_d;
`endif
    end
  end

  assign guess_ready = (state_q == ST_PLAY);
  assign draw_req    = (state_q == ST_LOAD_DRAW) || (state_q == ST_DRAW);
  assign won         = (state_q == ST_WON);
  assign lost        = (state_q == ST_LOST);
  assign word_len    = w_len;
  assign revealed    = revealed_q;
  assign miss_count  = miss_q;
  assign last_hit    = last_hit_q;

endmodule

`default_nettype wire

// File: doc/hangman_guess_engine.md
Name: hangman_guess_engine

Overview:
Parametrised word-guessing core for the VGA hangman game.
- Stores a secret word typed on the keyboard, then accepts guessed letters.
- Scans the stored word one position per cycle, updates a reveal mask and miss counter, and declares win or lose.
- Requests a screen redraw through a req/ack handshake with the VGA drawing logic.
- Sits between the keyboard decoder and the drawing FSMs; replaces the fixed 10-letter load/check pair.

Parameters:
MAX_LEN, 10, maximum word length in characters (2..16)
CHAR_W, 8, character code width (ASCII)
MAX_MISSES, 6, wrong guesses allowed; the MAX_MISSES-th miss loses
LEN_W, $clog2(MAX_LEN+1), derived width of word_len
MISS_W, $clog2(MAX_MISSES+1), derived width of miss_count

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
new_game  in  1  one-cycle pulse; abort any state and return to LOAD
key_valid  in  1  one-cycle strobe: key_code is a new keypress
key_code  in  CHAR_W  ASCII key; 8'h0A = enter, 8'h00 = none
guess_ready  out  1  high only in PLAY; a key_valid letter is accepted this cycle
word_len  out  LEN_W  number of stored characters
revealed  out  MAX_LEN  bit i = position i revealed (position 0 = first typed)
miss_count  out  MISS_W  wrong guesses so far
last_hit  out  1  latest resolved guess matched at least one position
draw_req  out  1  redraw request; held until draw_ack
draw_ack  in  1  drawing logic finished the redraw
won  out  1  sticky win flag
lost  out  1  sticky lose flag

Behaviour:
- Reset (async, resetn=0): state LOAD; word_len=0, revealed=0, miss_count=0, last_hit=0, draw_req=0, won=0, lost=0, guess_ready=0, storage cleared.
- Letters are 'A'..'Z' (8'h41..8'h5A). Any other non-enter key is ignored in every state.
- States: LOAD, LOAD_DRAW, PLAY, SCAN, RESOLVE, DRAW, WON, LOST.
- LOAD:
  - A letter writes to position word_len, then word_len increments.
  - Letters beyond MAX_LEN are dropped.
  - Enter with word_len>=1 goes to LOAD_DRAW. Enter with word_len=0 is ignored.
- LOAD_DRAW: assert draw_req; on draw_ack go to PLAY.
- PLAY:
  - guess_ready=1.
  - A letter with key_valid latches the guess, clears the scan index, and goes to SCAN next cycle.
- SCAN:
  - Compares position idx against the guess each cycle, idx 0..word_len-1.
  - On a match, sets revealed[idx] and a hit flag.
  - Positions already revealed are rescanned harmlessly.
  - Lasts exactly word_len cycles.
- RESOLVE (1 cycle):
  - last_hit <= hit.
  - On a miss, miss_count increments and saturates at MAX_MISSES.
  - Then goes to DRAW.
- DRAW:
  - draw_req=1 until the cycle draw_ack is sampled high.
  - Then: if revealed[word_len-1:0] is all ones, go to WON (won=1); else if miss_count==MAX_MISSES, go to LOST (lost=1); else go to PLAY.
  - Win is checked before lose.
- Latency: guess accepted at cycle T -> last_hit/miss_count valid at T+word_len+2 -> draw_req rises the same cycle.
- WON/LOST: outputs frozen; keys ignored; only new_game or reset exits.
- new_game has priority in every state: synchronous clear of all registers to reset values and go to LOAD. A pending draw_req is dropped.
- draw_ack outside LOAD_DRAW/DRAW is ignored.
- key_valid outside LOAD/PLAY is ignored; there is no queuing.

Optional Feature:
HANGMAN_REPEAT_TRACK_EN
- Defined:
  - A 26-bit used-letter mask is set in RESOLVE.
  - A guess of an already-used letter in PLAY is discarded: no state change, no miss, no redraw.
  - Adds output used_letters[25:0], bit 0 = 'A'.
  - The mask clears on reset or new_game.
- Undefined:
  - No mask and no used_letters port.
  - A repeated wrong letter costs another miss.
  - A repeated correct letter rescans and redraws with last_hit=1.

Decomposition:
- Package hangman_pkg:
  - State enum.
  - KEY_ENTER=8'h0A, KEY_NONE=8'h00, CHAR_A=8'h41, CHAR_Z=8'h5A.
  - Function is_letter(code).
- Sub-module hangman_word_store:
  - MAX_LEN x CHAR_W register file with write pointer/length counter.
  - Async read port indexed by the scan index.
  - Synchronous clear.
- The FSM, reveal mask and miss counter live in the top.

Test Plan:
- Load "CAT"+enter; ack draw; guess 'A' -> last_hit=1, revealed=10'b0000000010, miss_count=0; draw_req rises 5 cycles after acceptance.
- Word "CAT"; guess 'C','A','T' with acks -> won=1 after third DRAW ack; later keys ignored; guess_ready=0.
- Word "DOG", MAX_MISSES=6; guess 'X','Y','Z','Q','W','V' -> miss_count=6, lost=1, revealed=0.
- Enter with empty word -> stays in LOAD; type 12 letters with MAX_LEN=10, then enter -> word_len=10, letters 11-12 discarded.
- Hold draw_ack low for 20 cycles in DRAW -> draw_req stays high, no new guess accepted; pulse new_game mid-SCAN -> all outputs back to reset values, state LOAD.
- Word "AB"; guess 'X' twice -> miss_count=1 with HANGMAN_REPEAT_TRACK_EN (used_letters[23]=1), 2 without; async resetn low mid-PLAY -> immediate clear.
